// File: rtl/jt12_slot_pkg.sv
// Shared slot-code definitions: FSM states, legal channel constants,
// successor and code-to-linear helpers used by the decoder and sequencer.
package jt12_slot_pkg;

    localparam int unsigned CODE_W = 5;
    localparam int unsigned CH_W   = 3;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned MCNT_W = 3;
    localparam int unsigned ECNT_W = 8;

    // Channel field values that never appear in a legal code
    localparam logic [CH_W-1:0] CH_ILL_A = 3'd3;
    localparam logic [CH_W-1:0] CH_ILL_B = 3'd7;
    // Last channel of an operator group; successor wraps and bumps op here
    localparam logic [CH_W-1:0] CH_LAST  = 3'd6;

    typedef enum logic [1:0] {
        ST_UNSYNC  = 2'd0,
        ST_LOCKING = 2'd1,
        ST_LOCKED  = 2'd2
    } slot_state_t;

    function automatic logic code_legal(input logic [CODE_W-1:0] code);
        return (code[CH_W-1:0] != CH_ILL_A) && (code[CH_W-1:0] != CH_ILL_B);
    endfunction

    // Linear channel 0..5; illegal channels collapse to 0
    function automatic logic [CH_W-1:0] code_to_lin(input logic [CODE_W-1:0] code);
        logic [CH_W-1:0] ch;
        ch = code[CH_W-1:0];
        if (!code_legal(code)) return '0;
        return (ch < 3'd4) ? ch : CH_W'(ch - 3'd1);
    endfunction

    // Next code of the 24-slot cycle; illegal codes map to 0
    function automatic logic [CODE_W-1:0] code_succ(input logic [CODE_W-1:0] code);
        logic [CH_W-1:0] ch;
        logic [OP_W-1:0] op;
        ch = code[CH_W-1:0];
        op = code[CODE_W-1:CH_W];
        case (ch)
            3'd0:    return {op, 3'd1};
            3'd1:    return {op, 3'd2};
            3'd2:    return {op, 3'd4};
            3'd4:    return {op, 3'd5};
            3'd5:    return {op, CH_LAST};
            CH_LAST: return {OP_W'(op + 2'd1), 3'd0};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/jt12_slotdec_map.sv
// Combinational slot-code decode to linear channel, slot index and legality.
module jt12_slotdec_map
    import jt12_slot_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [CH_W-1:0]   ch_lin_c,
    output logic [IDX_W-1:0]  slot_idx_c,
    output logic              legal_c
);

    // slot_idx = op*6 + ch_lin, max 23 so 5 bits never overflow
    always_comb begin
        legal_c    = code_legal(code);
        ch_lin_c   = code_to_lin(code);
        slot_idx_c = IDX_W'(IDX_W'(code[CODE_W-1:CH_W]) * IDX_W'(6)) + IDX_W'(ch_lin_c);
    end

endmodule

// File: rtl/jt12_slotdec.sv
// Slot-code decoder with sequence lock tracking and saturating error count.
module jt12_slotdec
    import jt12_slot_pkg::*;
#(
    parameter int unsigned LOCK_MATCHES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic [CODE_W-1:0] slot_in,
    output logic              valid,
    output logic [CH_W-1:0]   ch_lin,
    output logic [OP_W-1:0]   op,
    output logic [IDX_W-1:0]  slot_idx,
    output logic              zero,
    output logic              locked,
    output logic              err,
    output logic [ECNT_W-1:0] err_cnt
);

    slot_state_t         state_q, state_d;
    logic [MCNT_W-1:0]   mcnt_q, mcnt_d;
    logic [CODE_W-1:0]   ref_q, ref_d;
    logic                valid_q, valid_d;
    logic [CH_W-1:0]     ch_lin_q, ch_lin_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [IDX_W-1:0]    slot_idx_q, slot_idx_d;
    logic                zero_q, zero_d;
    logic                locked_q, locked_d;
    logic                err_q, err_d;
    logic [ECNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [CH_W-1:0]     map_ch_lin_c;
    logic [IDX_W-1:0]    map_slot_idx_c;
    logic                map_legal_c;
    logic                match_c;

    jt12_slotdec_map u_map (
        .code       (slot_in),
        .ch_lin_c   (map_ch_lin_c),
        .slot_idx_c (map_slot_idx_c),
        .legal_c    (map_legal_c)
    );

    assign match_c = (slot_in == code_succ(ref_q));

    // Next-state, lock tracking and decoded-output update on each strobe
    always_comb begin
        state_d    = state_q;
        mcnt_d     = mcnt_q;
        ref_d      = ref_q;
        valid_d    = 1'b0;
        zero_d     = 1'b0;
        err_d      = 1'b0;
        ch_lin_d   = ch_lin_q;
        op_d       = op_q;
        slot_idx_d = slot_idx_q;
        err_cnt_d  = err_cnt_q;

        if (clk_en) begin
            valid_d    = 1'b1;
            ch_lin_d   = map_ch_lin_c;
            op_d       = slot_in[CODE_W-1:CH_W];
            slot_idx_d = map_slot_idx_c;
            zero_d     = (slot_in == '0);
            ref_d      = slot_in;

            case (state_q)
                ST_UNSYNC: begin
                    if (map_legal_c) begin
                        state_d = ST_LOCKING;
                        mcnt_d  = '0;
                    end
                end
                ST_LOCKING: begin
                    if (!map_legal_c) begin
                        state_d = ST_UNSYNC;
                        mcnt_d  = '0;
                    end else if (match_c) begin
                        if (32'(mcnt_q) + 32'd1 >= 32'(LOCK_MATCHES)) begin
                            state_d = ST_LOCKED;
                            mcnt_d  = '0;
                        end else begin
                            mcnt_d = MCNT_W'(mcnt_q + 3'd1);
                        end
                    end else begin
                        mcnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!map_legal_c) begin
                        err_d   = 1'b1;
                        state_d = ST_UNSYNC;
                        mcnt_d  = '0;
                    end else if (!match_c) begin
                        err_d   = 1'b1;
                        state_d = ST_LOCKING;
                        mcnt_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_UNSYNC;
                    mcnt_d  = '0;
                end
            endcase

            if (err_d && (err_cnt_q != '1)) begin
                err_cnt_d = ECNT_W'(err_cnt_q + 8'd1);
            end
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_UNSYNC;
            mcnt_q     <= '0;
            ref_q      <= '0;
            valid_q    <= 1'b0;
            ch_lin_q   <= '0;
            op_q       <= '0;
            slot_idx_q <= '0;
            zero_q     <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            mcnt_q     <= mcnt_d;
            ref_q      <= ref_d;
            valid_q    <= valid_d;
            ch_lin_q   <= ch_lin_d;
            op_q       <= op_d;
            slot_idx_q <= slot_idx_d;
            zero_q     <= zero_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign valid    = valid_q;
    assign ch_lin   = ch_lin_q;
    assign op       = op_q;
    assign slot_idx = slot_idx_q;
    assign zero     = zero_q;
    assign locked   = locked_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;

endmodule
